factorial_requester: RTL and testbench

- Initiator side of the factorial engine protocol (in_data/in_valid → out_data/out_valid/out_busy).
- Accepts operands from a host over a valid/ready stream and buffers them in a small FIFO.
- Issues operands to the engine one at a time, respecting busy, and waits for each result with a timeout.
- Returns {operand, result, timeout flag} to the host over a valid/ready response stream.

---
 rtl/factorial_pkg.sv | 22 ++
 rtl/factorial_requester_if.sv | 47 ++++
 rtl/req_fifo.sv | 79 +++++++
 rtl/factorial_requester.sv | 148 ++++++++++++++
 tb/tb_factorial_requester.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/factorial_pkg.sv
// Shared types and default widths for the factorial requester.
//   req_state_e : requester FSM states
//   rsp_t       : response payload {operand, data, timeout} at default widths
package factorial_pkg;

   localparam int unsigned IN_DATA_WD  = 4;
   localparam int unsigned OUT_DATA_WD = 46;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } req_state_e;

   typedef struct packed {
      logic [IN_DATA_WD-1:0]  operand;
      logic [OUT_DATA_WD-1:0] data;
      logic                   timeout;
   } rsp_t;

endpackage

// File: rtl/factorial_requester_if.sv
// Bundle of host-side and engine-side signals of the factorial requester.
//   master : requester view (drives req_ready, fact_in_*, rsp_*, err_stray)
//   slave  : host/engine view (drives req_data/valid, fact_out_*, fact_busy, rsp_ready)
interface factorial_requester_if #(
   parameter int unsigned IN_DATA_WD  = factorial_pkg::IN_DATA_WD,
   parameter int unsigned OUT_DATA_WD = factorial_pkg::OUT_DATA_WD
);

   logic [IN_DATA_WD-1:0]  req_data;
   logic                   req_valid;
   logic                   req_ready;

   logic [IN_DATA_WD-1:0]  fact_in_data;
   logic                   fact_in_valid;
   logic [OUT_DATA_WD-1:0] fact_out_data;
   logic                   fact_out_valid;
   logic                   fact_busy;

   logic [OUT_DATA_WD-1:0] rsp_data;
   logic [IN_DATA_WD-1:0]  rsp_operand;
   logic                   rsp_timeout;
   logic                   rsp_valid;
   logic                   rsp_ready;

   logic                   err_stray;

   modport master (
      input  req_data, req_valid,
      output req_ready,
      output fact_in_data, fact_in_valid,
      input  fact_out_data, fact_out_valid, fact_busy,
      output rsp_data, rsp_operand, rsp_timeout, rsp_valid,
      input  rsp_ready,
      output err_stray
   );

   modport slave (
      output req_data, req_valid,
      input  req_ready,
      input  fact_in_data, fact_in_valid,
      output fact_out_data, fact_out_valid, fact_busy,
      input  rsp_data, rsp_operand, rsp_timeout, rsp_valid,
      output rsp_ready,
      input  err_stray
   );

endinterface

// File: rtl/req_fifo.sv
// Synchronous operand FIFO with registered occupancy and flags.
//   push/push_data : write, accepted when not full or when popping in the same cycle
//   pop/pop_data   : head is visible on pop_data; pop advances when not empty
//   full/empty     : registered flags derived from next occupancy
//   count          : registered occupancy 0..DEPTH
module req_fifo #(
   parameter  int unsigned DATA_WD = 4,
   parameter  int unsigned DEPTH   = 4,
   localparam int unsigned PTR_WD  = $clog2(DEPTH),
   localparam int unsigned CNT_WD  = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               push,
   input  logic [DATA_WD-1:0] push_data,
   input  logic               pop,
   output logic [DATA_WD-1:0] pop_data,
   output logic               full,
   output logic               empty,
   output logic [CNT_WD-1:0]  count
);

   logic [DATA_WD-1:0] mem_q [DEPTH];
   logic [PTR_WD-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_WD-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_WD-1:0]  count_q, count_d;
   logic               full_q, full_d;
   logic               empty_q, empty_d;
   logic               push_ok_c;
   logic               pop_ok_c;

   // A push while full is legal only when the head leaves in the same cycle.
   assign push_ok_c = push && (!full_q || pop);
   assign pop_ok_c  = pop && !empty_q;

   // Pointer/occupancy next-state; pointers wrap naturally at power-of-two depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_WD'(1);
      if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PTR_WD'(1);
      case ({push_ok_c, pop_ok_c})
         2'b10:   count_d = count_q + CNT_WD'(1);
         2'b01:   count_d = count_q - CNT_WD'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CNT_WD'(DEPTH));
      empty_d = (count_d == '0);
   end

   // Control state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push_ok_c) mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign full     = full_q;
   assign empty    = empty_q;
   assign count    = count_q;

endmodule

// File: rtl/factorial_requester.sv
// Initiator for the factorial engine: buffers host operands, issues them one at
// a time to the engine, waits for the result with a timeout and returns
// {operand, result, timeout} to the host.
//   clk, resetn          : clock, async active-low reset
//   bus.req_*            : host operand stream (valid/ready)
//   bus.fact_in_*        : one-cycle issue strobe and operand to the engine
//   bus.fact_out_*, busy : engine result strobe/data and busy
//   bus.rsp_*            : host response stream (valid/ready)
//   bus.err_stray        : sticky flag, engine result seen outside WAIT
module factorial_requester
   import factorial_pkg::*;
#(
   parameter int unsigned IN_DATA_WD     = factorial_pkg::IN_DATA_WD,
   parameter int unsigned OUT_DATA_WD    = factorial_pkg::OUT_DATA_WD,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  resetn,
   factorial_requester_if.master bus
);

   localparam int unsigned TMR_WD = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int unsigned CNT_WD = $clog2(FIFO_DEPTH) + 1;

   req_state_e             state_q, state_d;
   logic [TMR_WD-1:0]      timer_q, timer_d;
   logic [IN_DATA_WD-1:0]  op_q, op_d;
   logic                   fact_in_valid_q, fact_in_valid_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [OUT_DATA_WD-1:0] rsp_data_q, rsp_data_d;
   logic [IN_DATA_WD-1:0]  rsp_operand_q, rsp_operand_d;
   logic                   rsp_timeout_q, rsp_timeout_d;
   logic                   err_stray_q, err_stray_d;

   logic                   fifo_push_c;
   logic                   fifo_pop_c;
   logic [IN_DATA_WD-1:0]  fifo_head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [CNT_WD-1:0]      fifo_count_unused;

   assign fifo_push_c = bus.req_valid && !fifo_full;

   req_fifo #(
      .DATA_WD (IN_DATA_WD),
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (fifo_push_c),
      .push_data (bus.req_data),
      .pop       (fifo_pop_c),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count_unused)
   );

   // Next-state, timer, issue strobe and response capture.
   always_comb begin
      state_d         = state_q;
      timer_d         = timer_q;
      op_d            = op_q;
      fact_in_valid_d = 1'b0;
      rsp_valid_d     = rsp_valid_q;
      rsp_data_d      = rsp_data_q;
      rsp_operand_d   = rsp_operand_q;
      rsp_timeout_d   = rsp_timeout_q;
      fifo_pop_c      = 1'b0;
      // Results are only expected while waiting; anything else latches the error.
      err_stray_d     = err_stray_q || (bus.fact_out_valid && (state_q != WAIT));

      case (state_q)
         IDLE: begin
            if (!fifo_empty && !bus.fact_busy) begin
               fifo_pop_c      = 1'b1;
               op_d            = fifo_head;
               fact_in_valid_d = 1'b1;
               state_d         = ISSUE;
            end
         end
         ISSUE: begin
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            timer_d = timer_q + TMR_WD'(1);
            // A result arriving on the last timeout cycle still wins.
            if (bus.fact_out_valid) begin
               rsp_data_d    = bus.fact_out_data;
               rsp_timeout_d = 1'b0;
               rsp_operand_d = op_q;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end else if (timer_q == TMR_WD'(TIMEOUT_CYCLES - 1)) begin
               rsp_data_d    = '0;
               rsp_timeout_d = 1'b1;
               rsp_operand_d = op_q;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q         <= IDLE;
         timer_q         <= '0;
         op_q            <= '0;
         fact_in_valid_q <= 1'b0;
         rsp_valid_q     <= 1'b0;
         rsp_data_q      <= '0;
         rsp_operand_q   <= '0;
         rsp_timeout_q   <= 1'b0;
         err_stray_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         timer_q         <= timer_d;
         op_q            <= op_d;
         fact_in_valid_q <= fact_in_valid_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_data_q      <= rsp_data_d;
         rsp_operand_q   <= rsp_operand_d;
         rsp_timeout_q   <= rsp_timeout_d;
         err_stray_q     <= err_stray_d;
      end
   end

   assign bus.req_ready     = !fifo_full;
   assign bus.fact_in_data  = op_q;
   assign bus.fact_in_valid = fact_in_valid_q;
   assign bus.rsp_data      = rsp_data_q;
   assign bus.rsp_operand   = rsp_operand_q;
   assign bus.rsp_timeout   = rsp_timeout_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.err_stray     = err_stray_q;

endmodule

// File: tb/tb_factorial_requester.sv
// Directed bench for factorial_requester: the bench plays host and engine.
module tb_factorial_requester;
   import factorial_pkg::*;

   logic clk;
   logic resetn;

   factorial_requester_if #(.IN_DATA_WD(4), .OUT_DATA_WD(46)) bus ();

   factorial_requester #(
      .IN_DATA_WD     (4),
      .OUT_DATA_WD    (46),
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int n_checks    = 0;
   int n_pass      = 0;
   int issue_cnt   = 0;
   int rsp_cycles  = 0;
   int overlap_cnt = 0;
   logic outstanding = 1'b0;
   logic [3:0] issue_q [$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Engine-side observer: logs issues and tracks outstanding operands.
   always @(posedge clk) begin
      if (!resetn) begin
         outstanding = 1'b0;
      end else begin
         if (bus.rsp_valid && bus.rsp_ready) outstanding = 1'b0;
         if (bus.fact_in_valid) begin
            if (outstanding) overlap_cnt++;
            outstanding = 1'b1;
            issue_cnt++;
            issue_q.push_back(bus.fact_in_data);
         end
         if (bus.rsp_valid) rsp_cycles++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] rsp_now();
      return 64'({bus.rsp_valid, bus.rsp_operand, bus.rsp_data, bus.rsp_timeout});
   endfunction

   function automatic logic [63:0] rsp_exp(input logic [3:0] op, input logic [45:0] res,
                                           input logic to);
      rsp_t r;
      r.operand = op;
      r.data    = res;
      r.timeout = to;
      return 64'({1'b1, r});
   endfunction

   // Wait for the next issue, answer after lat WAIT cycles, check the response.
   task automatic engine_serve(input string tag, input logic [3:0] op,
                               input logic [45:0] res, input int lat);
      bit found = 1'b0;
      logic [3:0] got = '0;
      for (int i = 0; i < 100; i++) begin
         if (issue_q.size() != 0) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk({tag, "_issue_seen"}, 64'(found), 64'd1);
      if (found) got = issue_q.pop_front();
      chk({tag, "_issue_op"}, 64'(got), 64'(op));
      repeat (lat) tick();
      bus.fact_out_data  = res;
      bus.fact_out_valid = 1'b1;
      chk({tag, "_rsp_before"}, 64'(bus.rsp_valid), 64'd0);
      tick();
      bus.fact_out_valid = 1'b0;
      bus.fact_out_data  = '0;
      chk({tag, "_rsp"}, rsp_now(), rsp_exp(op, res, 1'b0));
      if (bus.rsp_ready) begin
         tick();
         chk({tag, "_rsp_drop"}, 64'(bus.rsp_valid), 64'd0);
      end
   endtask

   initial begin
      int base_issue;
      int base_rsp;
      logic [3:0] got;

      resetn             = 1'b0;
      bus.req_data       = '0;
      bus.req_valid      = 1'b0;
      bus.fact_out_data  = '0;
      bus.fact_out_valid = 1'b0;
      bus.fact_busy      = 1'b0;
      bus.rsp_ready      = 1'b1;
      tick();
      tick();

      // Reset state
      chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
      chk("reset_issue", 64'({bus.fact_in_valid, bus.fact_in_data}), 64'd0);
      chk("reset_rsp", rsp_now(), 64'd0);
      chk("reset_err", 64'(bus.err_stray), 64'd0);
      resetn = 1'b1;
      tick();

      // Single operand 5 -> 120, with push-to-issue latency
      base_issue   = issue_cnt;
      bus.req_data  = 4'd5;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      chk("t1_issue_n1", 64'(bus.fact_in_valid), 64'd0);
      tick();
      chk("t1_issue_n2", 64'({bus.fact_in_valid, bus.fact_in_data}), 64'({1'b1, 4'd5}));
      engine_serve("t1", 4'd5, 46'd120, 2);
      chk("t1_one_pulse", 64'(issue_cnt - base_issue), 64'd1);

      // Back-to-back 0, 1, 15
      bus.req_valid = 1'b1;
      bus.req_data  = 4'd0;
      tick();
      bus.req_data  = 4'd1;
      tick();
      bus.req_data  = 4'd15;
      tick();
      bus.req_valid = 1'b0;
      engine_serve("t2a", 4'd0,  46'd1, 2);
      engine_serve("t2b", 4'd1,  46'd1, 2);
      engine_serve("t2c", 4'd15, 46'd1307674368000, 2);

      // Fill FIFO while engine busy
      bus.fact_busy = 1'b1;
      base_issue    = issue_cnt;
      bus.req_valid = 1'b1;
      bus.req_data  = 4'd2;
      tick();
      bus.req_data  = 4'd3;
      tick();
      bus.req_data  = 4'd4;
      tick();
      chk("t3_ready_3", 64'(bus.req_ready), 64'd1);
      bus.req_data  = 4'd6;
      tick();
      bus.req_valid = 1'b0;
      chk("t3_ready_full", 64'(bus.req_ready), 64'd0);
      repeat (3) tick();
      chk("t3_no_issue", 64'(issue_cnt - base_issue), 64'd0);
      chk("t3_still_full", 64'({bus.req_ready, bus.fact_in_valid}), 64'd0);
      bus.fact_busy = 1'b0;
      tick();
      chk("t3_ready_after_pop", 64'(bus.req_ready), 64'd1);
      chk("t3_issue", 64'({bus.fact_in_valid, bus.fact_in_data}), 64'({1'b1, 4'd2}));
      engine_serve("t3a", 4'd2, 46'd2,   1);
      engine_serve("t3b", 4'd3, 46'd6,   1);
      engine_serve("t3c", 4'd4, 46'd24,  1);
      engine_serve("t3d", 4'd6, 46'd720, 1);

      // Timeout on 7, then 8 issues normally
      bus.req_valid = 1'b1;
      bus.req_data  = 4'd7;
      tick();
      bus.req_data  = 4'd8;
      tick();
      bus.req_valid = 1'b0;
      tick();
      got = (issue_q.size() != 0) ? issue_q.pop_front() : 4'hx;
      chk("t4_issue_op", 64'(got), 64'd7);
      repeat (63) tick();
      chk("t4_before_timeout", 64'(bus.rsp_valid), 64'd0);
      tick();
      chk("t4_timeout_rsp", rsp_now(), rsp_exp(4'd7, 46'd0, 1'b1));
      tick();
      chk("t4_drop", 64'(bus.rsp_valid), 64'd0);
      engine_serve("t4b", 4'd8, 46'd40320, 1);

      // Back-pressured response with a stray result
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_data  = 4'd3;
      tick();
      bus.req_valid = 1'b0;
      engine_serve("t5", 4'd3, 46'd6, 2);
      chk("t5_err_before", 64'(bus.err_stray), 64'd0);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            bus.fact_out_valid = 1'b1;
            bus.fact_out_data  = 46'd999;
         end
         tick();
         bus.fact_out_valid = 1'b0;
         bus.fact_out_data  = '0;
         chk($sformatf("t5_hold_%0d", i), rsp_now(), rsp_exp(4'd3, 46'd6, 1'b0));
         chk($sformatf("t5_err_%0d", i), 64'(bus.err_stray), 64'(i >= 3));
      end
      bus.rsp_ready = 1'b1;
      tick();
      chk("t5_drop", 64'(bus.rsp_valid), 64'd0);
      chk("t5_err_sticky", 64'(bus.err_stray), 64'd1);

      // Reset during WAIT with two operands queued
      bus.req_valid = 1'b1;
      bus.req_data  = 4'd9;
      tick();
      bus.req_data  = 4'd10;
      tick();
      bus.req_data  = 4'd11;
      tick();
      bus.req_valid = 1'b0;
      got = (issue_q.size() != 0) ? issue_q.pop_front() : 4'hx;
      chk("t6_issue_op", 64'(got), 64'd9);
      tick();
      tick();
      resetn = 1'b0;
      #1;
      chk("t6_rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("t6_rst_issue", 64'({bus.fact_in_valid, bus.fact_in_data}), 64'd0);
      chk("t6_rst_rsp", rsp_now(), 64'd0);
      chk("t6_rst_err", 64'(bus.err_stray), 64'd0);
      tick();
      resetn     = 1'b1;
      base_issue = issue_cnt;
      base_rsp   = rsp_cycles;
      repeat (20) tick();
      chk("t6_no_issue", 64'(issue_cnt - base_issue), 64'd0);
      chk("t6_no_rsp", 64'(rsp_cycles - base_rsp), 64'd0);
      bus.req_valid = 1'b1;
      bus.req_data  = 4'd12;
      tick();
      bus.req_valid = 1'b0;
      engine_serve("t6b", 4'd12, 46'd479001600, 1);

      chk("no_overlap", 64'(overlap_cnt), 64'd0);
      chk("no_extra_issue", 64'(issue_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
